res_fifo: RTL and testbench

- Residual feature-map buffer for a residual layer.
- The write side captures each input pixel vector (FM_DEPTH channels × DATA_WIDTH) as it enters the layer's binary conv path.
- The read side replays that vector as the residual operand of the BN+residual stage.
- Read strobe is the BN stage's data_in_valid. res is registered so it changes on the same edge as the BN product register, keeping product and residual pixel-aligned.

---
 rtl/res_pkg.sv | 10 +
 rtl/res_fifo_ctrl.sv | 71 +++++++
 rtl/res_fifo.sv | 78 +++++++
 tb/tb_res_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/res_pkg.sv
// Shared definitions for the residual path: channel width, channels per
// pixel vector and the packed residual vector type.
package res_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FM_DEPTH   = 64;

  typedef logic signed [DATA_WIDTH-1:0] [FM_DEPTH-1:0] res_vec_t;

endpackage

// File: rtl/res_fifo_ctrl.sv
// Control path of the residual FIFO: pointers, occupancy, write-ready,
// accept strobes and sticky overflow/underflow flags.
// Optional build macro RES_FIFO_BYPASS_EN: a read on an empty buffer with a
// concurrent write forwards the write data instead of underflowing.
module res_fifo_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           clear,
  input  logic           wr_valid,
  input  logic           rd_en,
  output logic           wr_ready,
  output logic           wr_acc,
  output logic           rd_acc,
  output logic           bypass,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0] count,
  output logic           overflow,
  output logic           underflow
);

  localparam int CNT_W = PTR_W + 1;

  logic full;
  logic empty;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign wr_ready = !full | rd_en;

`ifdef RES_FIFO_BYPASS_EN
  assign bypass = !clear & empty & wr_valid & rd_en;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed write never touches storage; clear discards both ports.
  assign wr_acc = !clear & wr_valid & wr_ready & !bypass;
  assign rd_acc = !clear & rd_en & !empty;

  // Pointer, occupancy and sticky flag state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_valid & !wr_ready)   overflow  <= 1'b1;
      if (rd_en & empty & !bypass) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/res_fifo.sv
// Residual feature-map buffer: stores pixel vectors entering the binary conv
// path and replays them, registered, as the residual operand of the BN stage.
// Optional build macro RES_FIFO_BYPASS_EN (handled in res_fifo_ctrl).
module res_fifo #(
  parameter int DATA_WIDTH = res_pkg::DATA_WIDTH,
  parameter int FM_DEPTH   = res_pkg::FM_DEPTH,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic                                       clear,
  input  logic                                       wr_valid,
  input  logic signed [DATA_WIDTH-1:0] [FM_DEPTH-1:0] wr_data,
  output logic                                       wr_ready,
  input  logic                                       rd_en,
  output logic signed [DATA_WIDTH-1:0] [FM_DEPTH-1:0] res,
  output logic                                       res_valid,
  output logic [PTR_W:0]                             count,
  output logic                                       overflow,
  output logic                                       underflow
);

  logic signed [DATA_WIDTH-1:0] [FM_DEPTH-1:0] mem [FIFO_DEPTH];

  logic             wr_acc;
  logic             rd_acc;
  logic             bypass;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  res_fifo_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_W      (PTR_W)
  ) u_ctrl (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .wr_valid  (wr_valid),
    .rd_en     (rd_en),
    .wr_ready  (wr_ready),
    .wr_acc    (wr_acc),
    .rd_acc    (rd_acc),
    .bypass    (bypass),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // Residual output register: updates only on rd_en so the BN stage sees a
  // stable operand between pops, aligned with its product register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res       <= '0;
      res_valid <= 1'b0;
    end else if (clear) begin
      res       <= '0;
      res_valid <= 1'b0;
    end else if (rd_acc) begin
      res       <= mem[rd_ptr];
      res_valid <= 1'b1;
    end else if (bypass) begin
      res       <= wr_data;
      res_valid <= 1'b1;
    end else if (rd_en) begin
      res       <= '0;
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_res_fifo.sv
// Directed self-checking bench for res_fifo (default parameters).
module tb_res_fifo;
  import res_pkg::*;

  localparam int VW = DATA_WIDTH * FM_DEPTH;
  typedef logic [VW-1:0] flat_t;

  logic     clk = 1'b0;
  logic     rstn;
  logic     clear;
  logic     wr_valid;
  res_vec_t wr_data;
  logic     wr_ready;
  logic     rd_en;
  res_vec_t res;
  logic     res_valid;
  logic [4:0] count;
  logic     overflow;
  logic     underflow;

  flat_t res_f;
  assign res_f = res;

  int n_chk  = 0;
  int n_fail = 0;

  res_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FM_DEPTH   (FM_DEPTH),
    .FIFO_DEPTH (16)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_en     (rd_en),
    .res       (res),
    .res_valid (res_valid),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  function automatic flat_t vec(input int k);
    flat_t v;
    for (int c = 0; c < FM_DEPTH; c++) v[c*16 +: 16] = 16'(k*256 + c);
    return v;
  endfunction

  function automatic flat_t neg(input int n);
    flat_t v;
    for (int c = 0; c < FM_DEPTH; c++) v[c*16 +: 16] = {8'hFF, 8'(n*5 + c)};
    return v;
  endfunction

  function automatic flat_t fill8001();
    flat_t v;
    for (int c = 0; c < FM_DEPTH; c++) v[c*16 +: 16] = 16'h8001;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    clear = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_clear;
    idle(); clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; idle(); wr_data = '0;
    tick();
    n_chk++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_chk++; if (res_f !== '0) begin n_fail++; $display("FAIL reset_res: got %h want 0", res_f[255:0]); end
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    n_chk++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {overflow, underflow}); end
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    @(negedge clk); rstn = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain;
    for (int k = 0; k < 4; k++) begin wr_valid = 1'b1; wr_data = vec(k); tick(); end
    idle();
    n_chk++; if (count !== 5'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; tick();
      n_chk++; if (res_f !== vec(i)) begin n_fail++; $display("FAIL drain_res[%0d]: got %h want %h", i, res_f[255:0], vec(i) & 256'hFFFF_FFFF); end
      n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, res_valid); end
      n_chk++; if (count !== 5'(3 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 3 - i); end
    end
    idle(); tick(); tick();
    n_chk++; if (res_f !== vec(3)) begin n_fail++; $display("FAIL hold_res: got %h want vector 3", res_f[255:0]); end
    n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b want 1", res_valid); end
  endtask

  task automatic test_full;
    for (int k = 0; k < 16; k++) begin wr_valid = 1'b1; wr_data = vec(k); tick(); end
    idle();
    n_chk++; if (count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", count); end
    wr_valid = 1'b1; wr_data = vec(16); #1;
    n_chk++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready: got %b want 0", wr_ready); end
    tick();
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow: got %b want 1", overflow); end
    n_chk++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", count); end
    rd_en = 1'b1; #1;
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready: got %b want 1", wr_ready); end
    tick();
    idle();
    n_chk++; if (count !== 5'd16) begin n_fail++; $display("FAIL full_pushpop_count: got %0d want 16", count); end
    n_chk++; if (res_f !== vec(0)) begin n_fail++; $display("FAIL full_pushpop_res: got %h want vector 0", res_f[255:0]); end
    do_clear();
    n_chk++; if ({count, overflow} !== 6'd0) begin n_fail++; $display("FAIL full_clear: got count %0d ovf %b want 0 0", count, overflow); end
  endtask

  task automatic test_underflow;
    wr_valid = 1'b1; wr_data = vec(5); tick(); idle();
    rd_en = 1'b1; tick();
    n_chk++; if (res_f !== vec(5)) begin n_fail++; $display("FAIL uf_pre_res: got %h want vector 5", res_f[255:0]); end
    tick(); idle();
    n_chk++; if (res_f !== '0) begin n_fail++; $display("FAIL uf_res: got %h want 0", res_f[255:0]); end
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL uf_valid: got %b want 0", res_valid); end
    n_chk++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_flag: got %b want 1", underflow); end
    n_chk++; if (count !== 5'd0) begin n_fail++; $display("FAIL uf_count: got %0d want 0", count); end
    do_clear();
    wr_valid = 1'b1; rd_en = 1'b1; wr_data = fill8001(); tick(); idle();
`ifdef RES_FIFO_BYPASS_EN
    n_chk++; if (res_f !== fill8001()) begin n_fail++; $display("FAIL byp_res: got %h want all 8001", res_f[255:0]); end
    n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid: got %b want 1", res_valid); end
    n_chk++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL byp_underflow: got %b want 0", underflow); end
    n_chk++; if (count !== 5'd0) begin n_fail++; $display("FAIL byp_count: got %0d want 0", count); end
`else
    n_chk++; if (res_f !== '0) begin n_fail++; $display("FAIL nobyp_res: got %h want 0", res_f[255:0]); end
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL nobyp_valid: got %b want 0", res_valid); end
    n_chk++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL nobyp_underflow: got %b want 1", underflow); end
    n_chk++; if (count !== 5'd1) begin n_fail++; $display("FAIL nobyp_count: got %0d want 1", count); end
`endif
    do_clear();
  endtask

  task automatic test_wrap;
    for (int n = 0; n < 3; n++) begin wr_valid = 1'b1; wr_data = neg(n); tick(); end
    for (int i = 0; i < 40; i++) begin
      wr_valid = 1'b1; rd_en = 1'b1; wr_data = neg(i + 3); tick();
      n_chk++; if (res_f !== neg(i)) begin n_fail++; $display("FAIL wrap_res[%0d]: got %h want %h", i, res_f[255:0], neg(i) & {{(VW-256){1'b0}}, {256{1'b1}}}); end
      n_chk++; if (count !== 5'd3) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want 3", i, count); end
    end
    idle();
    n_chk++; if (res_f[VW-1] !== 1'b1) begin n_fail++; $display("FAIL wrap_sign: got %b want 1", res_f[VW-1]); end
    do_clear();
  endtask

  task automatic test_clear;
    rd_en = 1'b1; tick(); idle();
    for (int k = 0; k < 6; k++) begin wr_valid = 1'b1; wr_data = vec(20 + k); tick(); end
    idle(); rd_en = 1'b1; tick(); idle();
    n_chk++; if (count !== 5'd5) begin n_fail++; $display("FAIL clr_pre_count: got %0d want 5", count); end
    n_chk++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL clr_pre_underflow: got %b want 1", underflow); end
    clear = 1'b1; wr_valid = 1'b1; rd_en = 1'b1; wr_data = vec(30); tick(); idle();
    n_chk++; if (count !== 5'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", count); end
    n_chk++; if (res_f !== '0) begin n_fail++; $display("FAIL clr_res: got %h want 0", res_f[255:0]); end
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", res_valid); end
    n_chk++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL clr_flags: got %b want 00", {overflow, underflow}); end
    rd_en = 1'b1; tick(); idle();
    n_chk++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL clr_post_underflow: got %b want 1", underflow); end
    n_chk++; if (count !== 5'd0) begin n_fail++; $display("FAIL clr_post_count: got %0d want 0", count); end
    do_clear();
  endtask

  task automatic test_async_reset;
    for (int k = 0; k < 8; k++) begin wr_valid = 1'b1; wr_data = vec(40 + k); tick(); end
    idle(); rd_en = 1'b1; tick(); idle();
    n_chk++; if (count !== 5'd7) begin n_fail++; $display("FAIL ar_pre_count: got %0d want 7", count); end
    #2; rstn = 1'b0; #1;
    n_chk++; if (count !== 5'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", count); end
    n_chk++; if (res_f !== '0) begin n_fail++; $display("FAIL ar_res: got %h want 0", res_f[255:0]); end
    n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", res_valid); end
    n_chk++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL ar_flags: got %b want 00", {overflow, underflow}); end
    @(negedge clk); rstn = 1'b1;
    tick();
    wr_valid = 1'b1; wr_data = vec(50); tick(); idle();
    rd_en = 1'b1; tick(); idle();
    n_chk++; if (res_f !== vec(50)) begin n_fail++; $display("FAIL ar_post_res: got %h want vector 50", res_f[255:0]); end
    n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL ar_post_valid: got %b want 1", res_valid); end
    n_chk++; if (count !== 5'd0) begin n_fail++; $display("FAIL ar_post_count: got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full();
    test_underflow();
    test_wrap();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
